// File: rtl/cga_mode_init_if.sv
// rtl/cga_mode_init_if.sv - ISA I/O bus between the mode-set initiator and the CGA register responder
interface cga_mode_init_if;
  logic [15:0] bus_a;
  logic [15:0] bus_d;
  logic        word;
  logic        bus_iow_l;
  logic        bus_ior_l;
  logic        bus_aen;
  logic [7:0]  bus_in;

  modport master (output bus_a, bus_d, word, bus_iow_l, bus_ior_l, bus_aen, input bus_in);
  modport slave  (input bus_a, bus_d, word, bus_iow_l, bus_ior_l, bus_aen, output bus_in);
endinterface

// File: rtl/cga_mode_init.sv
// rtl/cga_mode_init.sv - BIOS mode-set sequencer driving the CGA register port as an ISA I/O initiator
module cga_mode_init #(
  parameter logic [15:0] IO_BASE_ADDR  = 16'h3D0,
  parameter int          IOW_LEN       = 2,
  parameter int          IOR_LEN       = 2,
  parameter logic [19:0] VSYNC_TIMEOUT = 20'd1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      mode,
  output logic            busy,
  output logic            done,
  output logic            err,
  cga_mode_init_if.master io
);

  localparam logic [7:0] IOW_LAST = 8'(IOW_LEN - 1);
  localparam logic [7:0] IOR_LAST = 8'(IOR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  step_q, step_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] to_q, to_d;
  logic [2:0]  mode_q, mode_d;
  logic        err_q, err_d;
  logic        vs_q, vs_d;

  function automatic logic [7:0] mode_val(input logic [2:0] m);
    case (m)
      3'd0:    mode_val = 8'h2C;
      3'd1:    mode_val = 8'h28;
      3'd2:    mode_val = 8'h2D;
      3'd3:    mode_val = 8'h29;
      3'd4:    mode_val = 8'h2A;
      3'd5:    mode_val = 8'h2E;
      3'd6:    mode_val = 8'h1E;
      default: mode_val = 8'h00;
    endcase
  endfunction

  // Text modes share everything except the horizontal timing; graphics differs in vertical timing.
  function automatic logic [7:0] crtc_val(input logic [2:0] m, input logic [3:0] r);
    logic txt80, gfx;
    txt80 = (m == 3'd2) || (m == 3'd3);
    gfx   = (m >= 3'd4);
    case (r)
      4'd0:    crtc_val = txt80 ? 8'h71 : 8'h38;
      4'd1:    crtc_val = txt80 ? 8'h50 : 8'h28;
      4'd2:    crtc_val = txt80 ? 8'h5A : 8'h2D;
      4'd3:    crtc_val = 8'h0A;
      4'd4:    crtc_val = gfx ? 8'h7F : 8'h1F;
      4'd5:    crtc_val = 8'h06;
      4'd6:    crtc_val = gfx ? 8'h64 : 8'h19;
      4'd7:    crtc_val = gfx ? 8'h70 : 8'h1C;
      4'd8:    crtc_val = 8'h02;
      4'd9:    crtc_val = gfx ? 8'h01 : 8'h07;
      4'd10:   crtc_val = 8'h06;
      4'd11:   crtc_val = 8'h07;
      default: crtc_val = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= 6'd0;
      cnt_q   <= 8'd0;
      to_q    <= 20'd0;
      mode_q  <= 3'd0;
      err_q   <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      vs_q    <= vs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    mode_d  = mode_q;
    err_d   = err_q;
    vs_d    = vs_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d  = mode;
        step_d  = 6'd0;
        err_d   = (mode == 3'd7);
        state_d = (mode == 3'd7) ? FINISH : W_SETUP;
      end
      W_SETUP: begin
        cnt_d   = 8'd0;
        state_d = W_STROBE;
      end
      W_STROBE: if (cnt_q == IOW_LAST) state_d = W_HOLD;
                else cnt_d = cnt_q + 8'd1;
      W_HOLD: begin
        if (step_q == 6'd34) begin
          state_d = FINISH;
        end else if (step_q == 6'd33) begin
          to_d    = 20'd0;
          state_d = R_SETUP;
        end else begin
          step_d  = step_q + 6'd1;
          state_d = W_SETUP;
        end
      end
      // to_q counts every clock spent in the poll loop, including the current one.
      R_SETUP: begin
        cnt_d   = 8'd0;
        to_d    = to_q + 20'd1;
        state_d = R_STROBE;
      end
      R_STROBE: begin
        to_d = to_q + 20'd1;
        if (cnt_q == IOR_LAST) begin
          vs_d    = io.bus_in[3];
          state_d = R_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      R_HOLD: begin
        if (!vs_q && (to_q + 20'd1 < VSYNC_TIMEOUT)) begin
          to_d    = to_q + 20'd1;
          state_d = R_SETUP;
        end else begin
          err_d   = !vs_q;
          step_d  = 6'd34;
          state_d = W_SETUP;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Steps 1..32 alternate index/data writes; step_lo[0] selects which, step_lo[4:1] is the register.
  logic [4:0]  step_lo;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  always_comb begin
    step_lo = step_q[4:0] - 5'd1;
    wr_addr = IO_BASE_ADDR + 16'h8;
    wr_data = mode_val(mode_q) & 8'hF7;
    if (step_q == 6'd33) begin
      wr_addr = IO_BASE_ADDR + 16'h9;
      wr_data = (mode_q == 3'd6) ? 8'h3F : 8'h30;
    end else if (step_q == 6'd34) begin
      wr_addr = IO_BASE_ADDR + 16'h8;
      wr_data = mode_val(mode_q);
    end else if (step_q != 6'd0) begin
      if (!step_lo[0]) begin
        wr_addr = IO_BASE_ADDR + 16'h4;
        wr_data = {4'h0, step_lo[4:1]};
      end else begin
        wr_addr = IO_BASE_ADDR + 16'h5;
        wr_data = crtc_val(mode_q, step_lo[4:1]);
      end
    end
  end

  always_comb begin
    io.bus_a = 16'h0000;
    io.bus_d = 16'h0000;
    case (state_q)
      W_SETUP, W_STROBE, W_HOLD: begin
        io.bus_a = wr_addr;
        io.bus_d = {8'h00, wr_data};
      end
      R_SETUP, R_STROBE, R_HOLD: io.bus_a = IO_BASE_ADDR + 16'hA;
      default: ;
    endcase
  end

  assign io.word      = 1'b0;
  assign io.bus_iow_l = (state_q != W_STROBE);
  assign io.bus_ior_l = (state_q != R_STROBE);
  assign io.bus_aen   = (state_q == IDLE);
  assign busy         = (state_q != IDLE) && (state_q != FINISH);
  assign done         = (state_q == FINISH);
  assign err          = err_q;

  logic unused_rd;
  assign unused_rd = ^{io.bus_in[7:4], io.bus_in[2:0]};

endmodule

// File: tb/tb_cga_mode_init.sv
// tb/tb_cga_mode_init.sv - scoreboard bench for the CGA mode-set sequencer
module tb_cga_mode_init;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start2;
  logic [2:0] mode, mode2;
  logic       busy, done, err, busy2, done2, err2;

  cga_mode_init_if bus_if();
  cga_mode_init_if bus_if2();

  cga_mode_init dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err), .io(bus_if)
  );

  cga_mode_init #(.VSYNC_TIMEOUT(20'd100)) dut_to (
    .clk(clk), .reset(reset), .start(start2), .mode(mode2),
    .busy(busy2), .done(done2), .err(err2), .io(bus_if2)
  );

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_total = 0;
  int   vs_after = 0;

  // Retrace bit reads as set once the current read index passes vs_after.
  assign bus_if.bus_in  = (rd_total > vs_after) ? 8'h08 : 8'h00;
  assign bus_if2.bus_in = 8'h00;

  logic [7:0] mv_tab  [0:6]  = '{8'h2C, 8'h28, 8'h2D, 8'h29, 8'h2A, 8'h2E, 8'h1E};
  logic [7:0] col_tab [0:6]  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h3F};
  logic [7:0] t40     [0:15] = '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                                 8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] t80     [0:15] = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                                 8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] gtab    [0:15] = '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
                                 8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void push(int k, logic [15:0] a, logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endfunction

  function automatic void push_seq(int m, int nreads, logic e);
    push(0, 16'h3D8, mv_tab[m] & 8'hF7);
    for (int r = 0; r < 16; r++) begin
      push(0, 16'h3D4, 8'(r));
      push(0, 16'h3D5, (m < 2) ? t40[r] : (m < 4) ? t80[r] : gtab[r]);
    end
    push(0, 16'h3D9, col_tab[m]);
    for (int i = 0; i < nreads; i++) push(1, 16'h3DA, 8'h00);
    push(0, 16'h3D8, mv_tab[m]);
    push(2, 16'h0000, {7'd0, e});
  endfunction

  function automatic void pop_cmp(int k, logic [15:0] a, logic [7:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_addr", {16'h0, a}, {16'h0, e.a});
      chk("event_data", {24'h0, d}, {24'h0, e.d});
    end
  endfunction

  logic piow = 1'b1, pior = 1'b1;
  int   wlen = 0, rlen = 0;
  always @(negedge clk) begin
    if (reset) begin
      piow = 1'b1; pior = 1'b1; wlen = 0; rlen = 0;
    end else begin
      chk("strobe_overlap", {31'd0, !bus_if.bus_iow_l && !bus_if.bus_ior_l}, 0);
      chk("aen_in_strobe", {31'd0, (!bus_if.bus_iow_l || !bus_if.bus_ior_l) && bus_if.bus_aen}, 0);
      if (!bus_if.bus_iow_l) begin
        if (piow) begin
          chk("wr_hi_byte", {24'h0, bus_if.bus_d[15:8]}, 0);
          pop_cmp(0, bus_if.bus_a, bus_if.bus_d[7:0]);
        end
        wlen++;
      end else if (!piow) begin
        chk("iow_len", wlen, 2);
        wlen = 0;
      end
      if (!bus_if.bus_ior_l) begin
        if (pior) begin
          rd_total++;
          pop_cmp(1, bus_if.bus_a, 8'h00);
        end
        rlen++;
      end else if (!pior) begin
        chk("ior_len", rlen, 2);
        rlen = 0;
      end
      if (done) pop_cmp(2, 16'h0000, {7'd0, err});
      piow = bus_if.bus_iow_l;
      pior = bus_if.bus_ior_l;
    end
  end

  int          rd2 = 0, wr2 = 0;
  logic        piow2 = 1'b1, pior2 = 1'b1;
  logic [15:0] last_a2 = 16'h0;
  logic [7:0]  last_d2 = 8'h0;
  always @(negedge clk) begin
    if (!bus_if2.bus_ior_l && pior2) rd2++;
    if (!bus_if2.bus_iow_l && piow2) begin
      wr2++;
      last_a2 = bus_if2.bus_a;
      last_d2 = bus_if2.bus_d[7:0];
    end
    pior2 = bus_if2.bus_ior_l;
    piow2 = bus_if2.bus_iow_l;
  end

  task automatic go(input logic [2:0] m, input bit spam, output int n, output logic b1,
                    output logic e1, output int fi);
    start = 1'b1;
    mode  = m;
    fi    = -1;
    @(posedge clk); #1;
    n     = 1;
    b1    = busy;
    start = 1'b0;
    while (n < 3000) begin
      if (fi < 0 && !bus_if.bus_iow_l) fi = n;
      if (spam) begin
        start = (n % 4 == 1);
        mode  = 3'd2;
      end
      if (done) break;
      @(posedge clk); #1;
      n++;
    end
    e1 = err;
    chk("done_seen", {31'd0, done}, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(string name);
    repeat (4) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int   n, fi;
    logic b1, e1;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; mode = 3'd0; mode2 = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    chk("rst_bus_a", {16'h0, bus_if.bus_a}, 0);
    chk("rst_bus_d", {16'h0, bus_if.bus_d}, 0);
    chk("rst_word_iow_ior_aen", {28'd0, bus_if.word, bus_if.bus_iow_l, bus_if.bus_ior_l, bus_if.bus_aen}, 32'h7);
    reset = 1'b0;
    @(posedge clk); #1;

    vs_after = rd_total;
    push_seq(3, 1, 1'b0);
    go(3'd3, 1'b0, n, b1, e1, fi);
    chk("m3_done_cycle", n, 145);
    chk("m3_busy_at_1", {31'd0, b1}, 1);
    chk("m3_first_iow", fi, 2);
    chk("m3_err", {31'd0, e1}, 0);
    settle("m3_queue_empty");

    vs_after = rd_total + 50;
    push_seq(6, 51, 1'b0);
    go(3'd6, 1'b0, n, b1, e1, fi);
    chk("m6_err", {31'd0, e1}, 0);
    settle("m6_queue_empty");

    push(2, 16'h0000, 8'h01);
    go(3'd7, 1'b0, n, b1, e1, fi);
    chk("m7_done_cycle", n, 1);
    chk("m7_busy", {31'd0, b1}, 0);
    chk("m7_err", {31'd0, e1}, 1);
    settle("m7_queue_empty");

    vs_after = rd_total;
    push_seq(3, 1, 1'b0);
    start = 1'b1; mode = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(!bus_if.bus_iow_l && bus_if.bus_a == 16'h3D4 && bus_if.bus_d == 16'h0009) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    while (!(!bus_if.bus_iow_l && bus_if.bus_a == 16'h3D5) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("r9_strobe_reached", {31'd0, n < 500}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_iow", {31'd0, bus_if.bus_iow_l}, 1);
    chk("rst_mid_aen", {31'd0, bus_if.bus_aen}, 1);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;

    vs_after = rd_total;
    push_seq(4, 1, 1'b0);
    go(3'd4, 1'b0, n, b1, e1, fi);
    chk("m4_done_cycle", n, 145);
    chk("m4_err", {31'd0, e1}, 0);
    settle("m4_queue_empty");

    vs_after = rd_total;
    push_seq(0, 1, 1'b0);
    go(3'd0, 1'b1, n, b1, e1, fi);
    chk("spam_done_cycle", n, 145);
    settle("spam_queue_empty");

    start2 = 1'b1; mode2 = 3'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("to_done", {31'd0, done2}, 1);
    chk("to_err", {31'd0, err2}, 1);
    chk("to_reads_25_or_26", {31'd0, rd2 >= 25 && rd2 <= 26}, 1);
    chk("to_write_count", wr2, 35);
    chk("to_final_addr", {16'h0, last_a2}, 32'h3D8);
    chk("to_final_data", {24'h0, last_d2}, 32'h28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cga_mode_init.md
# cga_mode_init

Hardware mode-set sequencer acting as the ISA I/O initiator for the CGA adapter's register port. On a start pulse it programs a standard BIOS video mode (0–6). It blanks video through the mode control register, loads all 16 MC6845 CRTC registers through the index/data pair, and writes the color select register. It then polls the status register for vertical retrace and re-enables video. It sits beside the CPU bus master and drives the same I/O lines the CGA block decodes.

## Interface
- IO_BASE_ADDR, 16'h3D0, base of the CGA register window; index = +4, data = +5, mode = +8, color = +9, status = +A
- IOW_LEN, 2, clocks bus_iow_l is held low per write (≥2, because the responder resynchronises the strobe)
- IOR_LEN, 2, clocks bus_ior_l is held low per read (≥1)
- VSYNC_TIMEOUT, 20'd1000000, maximum clocks spent polling for retrace
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy
- mode  in  3  BIOS mode number, sampled when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at the end of a sequence
- err  out  1  valid with done: invalid mode or retrace timeout
- bus_a  out  16  I/O address
- bus_d  out  16  write data; [15:8] always 0
- word  out  1  always 0 (byte cycles only)
- bus_iow_l  out  1  I/O write strobe, active low
- bus_ior_l  out  1  I/O read strobe, active low
- bus_aen  out  1  high when idle (decoders ignore the bus); low during own cycles
- bus_in  in  8  read data returned by the responder

## Operation
- Reset values: busy=0, done=0, err=0, bus_a=0, bus_d=0, word=0, bus_iow_l=1, bus_ior_l=1, bus_aen=1, state IDLE.
- Mode table (mode value / color value / CRTC set):
  - 0: 2C / 30 / T40
  - 1: 28 / 30 / T40
  - 2: 2D / 30 / T80
  - 3: 29 / 30 / T80
  - 4: 2A / 30 / G
  - 5: 2E / 30 / G
  - 6: 1E / 3F / G
- CRTC sets, R0..R15:
  - T40 = 38 28 2D 0A 1F 06 19 1C 02 07 06 07 00 00 00 00
  - T80 = 71 50 5A 0A 1F 06 19 1C 02 07 06 07 00 00 00 00
  - G = 38 28 2D 0A 7F 06 64 70 02 01 06 07 00 00 00 00
- Step sequence (step counter 0..34):
  - step 0: write base+8 with mode value & ~08 (video off)
  - steps 1..32: for r = 0..15, write base+4 = r, then base+5 = table[r]
  - step 33: write base+9 with the color value
  - retrace poll: read base+A repeatedly until bus_in[3]=1
  - step 34: write base+8 with the full mode value
  - then pulse done
- mode=7 on start: no bus cycles, busy stays 0, and done=1 with err=1 on the next cycle.
- Retrace timeout: if the poll exceeds VSYNC_TIMEOUT clocks, abandon polling, still perform step 34, and finish with done=1, err=1.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD, FINISH.
  - IDLE→W_SETUP on an accepted start.
  - W_HOLD→W_SETUP on the next step, or →R_SETUP after step 33, or →FINISH after step 34.
  - R_HOLD→R_SETUP if bit 3 is clear and the timeout has not expired; otherwise →W_SETUP (step 34).
  - FINISH→IDLE.
- err is cleared on the next accepted start.
- A start in the same cycle as done's FINISH is ignored; start is sampled only in IDLE.

## Timing
- Write cycle = 1 + IOW_LEN + 1 clocks:
  - SETUP: bus_aen=0; bus_a and bus_d valid; strobes high.
  - STROBE: bus_iow_l=0 for IOW_LEN clocks; bus_a and bus_d stable.
  - HOLD: bus_iow_l=1; bus_a and bus_d still stable.
  - bus_aen returns to 1 only in IDLE.
- Read cycle = 1 + IOR_LEN + 1 clocks. bus_in is sampled on the last STROBE clock.
- bus_iow_l and bus_ior_l are never low simultaneously, and never low in SETUP or HOLD.
- Latency with defaults (immediate retrace): start@0 → busy@1 → first iow low@2.
  - 34 writes = 136 clocks, one read = 4 clocks, final write = 4 clocks.
  - done@145.
- Reset asserted mid-cycle: at the next edge all outputs take their reset values (strobes high, aen high). No partial sequence resumes.

## Test plan
- Mode 3, responder returns bus_in[3]=1 immediately:
  - 35 write cycles in order: 3D8←21, then 3D4/3D5 pairs 00/71 … 0F/00, then 3D9←30, one read of 3DA, then 3D8←29.
  - done pulses at clock 145 with err=0; iow low exactly 2 clocks each.
- Mode 6, retrace bit held 0 for 50 reads:
  - 3D9←3F; exactly 51 reads issued; final 3D8←1E; err=0.
- Mode 7: no strobe activity; done and err both high one cycle after start; busy never asserts.
- VSYNC_TIMEOUT=100, bus_in[3] stuck 0:
  - polling stops within 100 clocks plus one read cycle, 3D8←mode value is still written, done=1 with err=1.
- Reset asserted during the strobe of CRTC write R9:
  - next clock has bus_iow_l=1, bus_aen=1, busy=0.
  - a subsequent start of mode 4 runs the full sequence from step 0 (3D8←22).
- start pulsed repeatedly while busy (mode 0 running, mode 2 requested): requests ignored, the sequence completes with mode 0 values, one done pulse.
